// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral (MSB first) that owns NUM_REGS control
// registers of DATA_W bits each and exposes them as flat outputs.
//
// A frame is 1+ADDR_W+DATA_W bits long: R/W (1 = write), then the address,
// then the data. Writes are committed atomically when nCS rises on a complete
// frame. On a read frame the register is snapshotted when the data phase
// starts, and the snapshot is shifted out on cipo_o.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ncs_i       SPI chip select (active low, asynchronous)
//   sclk_i      SPI clock (idle low, asynchronous)
//   copi_i      SPI controller-out data (asynchronous)
//   cipo_o      SPI controller-in data (read frames)
//   cipo_oe_o   output enable for cipo_o
//   regs_o      register contents; register k at [k*DATA_W +: DATA_W]
//   wr_strobe_o one-cycle pulse; bit k is set in the cycle register k updates
//   err_o       one-cycle pulse on a discarded or invalid frame
module spi_reg_bank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs_i,
    input  logic                       sclk_i,
    input  logic                       copi_i,
    output logic                       cipo_o,
    output logic                       cipo_oe_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_strobe_o,
    output logic                       err_o
);
    localparam int CMD_W = 1 + ADDR_W;
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_FULL,
        S_OVERRUN
    } state_t;

    // Synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   ncs_prev_q;
    logic                   sclk_prev_q;
    logic                   ncs_s;
    logic                   sclk_s;
    logic                   copi_s;
    logic                   ncs_fall;
    logic                   ncs_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // Frame state
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CMD_W-1:0]       cmd_q;
    logic [CMD_W-1:0]       cmd_next;
    logic [DATA_W-1:0]      data_q;
    logic [DATA_W-1:0]      rd_q;
    logic [DATA_W-1:0]      snap;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_strobe_q;
    logic                   err_q;
    logic [NUM_REGS-1:0]    hit_cur;
    logic [NUM_REGS-1:0]    hit_next;
    logic                   addr_ok;

    // Control decoded by the FSM
    logic                   frame_start;
    logic                   cmd_shift;
    logic                   data_shift;
    logic                   enter_data;
    logic                   rd_shift;
    logic                   commit;
    logic                   frame_err;

    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    // SCLK edges only count while the synchronised chip select is low.
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~ncs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~ncs_s;

    assign cmd_next = {cmd_q[CMD_W-2:0], copi_s};

    // Address decode: hit_cur for the latched address (commit/error),
    // hit_next for the address completing on this SCLK edge (snapshot).
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign hit_cur[gi]  = (cmd_q[ADDR_W-1:0] == ADDR_W'(gi));
        assign hit_next[gi] = (cmd_next[ADDR_W-1:0] == ADDR_W'(gi));
        assign regs_o[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    assign addr_ok = |hit_cur;

    // Out-of-range addresses match nothing and read back as zero.
    always_comb begin
        snap = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hit_next[k]) begin
                snap = regs_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        cmd_shift   = 1'b0;
        data_shift  = 1'b0;
        enter_data  = 1'b0;
        commit      = 1'b0;
        frame_err   = 1'b0;
        // The SCLK fall that immediately follows the data-phase entry must
        // not shift: the snapshot MSB has to survive until the first data
        // rising edge. Later falls (cnt_q != 0) advance to the next bit.
        rd_shift    = sclk_fall &&
                      ((state_q == S_DATA && cnt_q != '0) || state_q == S_FULL);
        if (ncs_rise) begin
            state_d = S_IDLE;
            case (state_q)
                S_CMD:            frame_err = (cnt_q != '0);
                S_DATA, S_OVERRUN: frame_err = 1'b1;
                S_FULL: begin
                    if (!addr_ok) begin
                        frame_err = 1'b1;
                    end else if (cmd_q[ADDR_W]) begin
                        commit = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ncs_fall) begin
                        state_d     = S_CMD;
                        frame_start = 1'b1;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_shift = 1'b1;
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            state_d    = S_DATA;
                            enter_data = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (sclk_rise) begin
                        data_shift = 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (sclk_rise) begin
                        state_d = S_OVERRUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            wr_strobe_q <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= frame_err;
            if (frame_start) begin
                cnt_q  <= '0;
                cmd_q  <= '0;
                data_q <= '0;
                rd_q   <= '0;
            end
            if (cmd_shift) begin
                cmd_q <= cmd_next;
                cnt_q <= enter_data ? '0 : cnt_q + CNT_W'(1);
            end
            if (data_shift) begin
                data_q <= {data_q[DATA_W-2:0], copi_s};
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (enter_data) begin
                rd_q <= snap;
            end else if (rd_shift) begin
                rd_q <= {rd_q[DATA_W-2:0], 1'b0};
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                wr_strobe_q[k] <= commit && hit_cur[k];
                if (commit && hit_cur[k]) begin
                    regs_q[k] <= data_q;
                end
            end
        end
    end

    assign cipo_oe_o   = ~cmd_q[ADDR_W] && (state_q == S_DATA || state_q == S_FULL);
    assign cipo_o      = cipo_oe_o & rd_q[DATA_W-1];
    assign wr_strobe_o = wr_strobe_q;
    assign err_o       = err_q;

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI peripheral (mode 0, MSB first) that owns a bank of NUM_REGS control registers of DATA_W bits each and exposes them as flat outputs to the chip's output-enable/PWM logic. It supports both write and read-back frames, synchronises the asynchronous SPI pins into `clk`, and commits writes atomically at frame end. It reports malformed frames. It sits between the top-level `ui_in` pins and the PWM/output-enable datapath.

## Interface
- ADDR_W, 7, address field width in bits
- DATA_W, 8, register and data field width in bits
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
- SYNC_STAGES, 2, flip-flop synchroniser depth on ncs/copi/sclk (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ncs_i  in  1  SPI chip select, active low, asynchronous
- sclk_i  in  1  SPI clock, idle low, asynchronous
- copi_i  in  1  SPI controller-out data, asynchronous
- cipo_o  out  1  SPI controller-in data (read frames)
- cipo_oe_o  out  1  output enable for cipo_o
- regs_o  out  NUM_REGS*DATA_W  register contents; register k at [k*DATA_W +: DATA_W]
- wr_strobe_o  out  NUM_REGS  one-cycle pulse, bit k set in the cycle register k updates
- err_o  out  1  one-cycle pulse on a discarded or invalid frame

## Operation
- Frame: FRAME_LEN = 1+ADDR_W+DATA_W bits (16 by default). Bit 0 = R/W (1 = write), then address MSB first, then data MSB first. All bits are sampled on synchronised SCLK rising edges while synchronised nCS is low.
- FSM states:
  - IDLE: nCS falling -> CMD, bit counter cleared.
  - CMD: shift R/W+address. After bit 1+ADDR_W -> DATA.
  - DATA: shift data. After DATA_W bits -> FULL.
  - FULL: any further SCLK rising edge -> OVERRUN.
  - Any state: nCS rising -> IDLE.
- Write commit: nCS rises in FULL and R/W=1 and address<NUM_REGS -> register[address] <= data, with the matching wr_strobe_o bit pulsed.
- Read: at the entry to DATA, register[address] is snapshotted into a shift register (0 if address>=NUM_REGS). cipo_oe_o=1 while in DATA/FULL of a read frame. cipo_o presents the snapshot MSB first. Each bit changes on the synchronised SCLK falling edge; the first bit is valid from the DATA entry. Data bits received on COPI during a read are ignored.
- err_o pulses on nCS rising when any of the following holds; no register changes:
  - state is CMD, DATA or OVERRUN (short or long frame)
  - address>=NUM_REGS
- Registers never change other than at commit. A read frame never modifies state.
- SCLK edges while nCS is high are ignored. nCS glitches that return high in IDLE/CMD with zero bits produce err_o only if at least one bit was shifted.
- Reset (any time, including mid-frame): regs_o=0, wr_strobe_o=0, err_o=0, cipo_o=0, cipo_oe_o=0, FSM=IDLE, counters/shift registers cleared, synchronisers cleared to 0 except the ncs synchroniser, which is cleared to 1.

## Timing
- Input latency: SYNC_STAGES clk cycles, plus 1 cycle for edge detection.
- Write commit: regs_o and wr_strobe_o update SYNC_STAGES+1 cycles after the nCS rising edge at the pin. wr_strobe_o is high exactly 1 cycle. err_o has the same timing.
- cipo_o/cipo_oe_o lag the SCLK falling edge by SYNC_STAGES+1 cycles.
- Requirements on the controller:
  - SCLK high and low phases are each >= SYNC_STAGES+2 clk cycles.
  - nCS high time between frames is >= SYNC_STAGES+2 cycles.
  - nCS setup/hold to SCLK is >= 1 SCLK half-period.
- Back-to-back frames are supported. A commit and the next frame's nCS fall are never merged.

## Test plan
- Write 0xA5 to addr 0, then 0x3C to addr 4 (defaults) -> regs_o[7:0]=0xA5, regs_o[39:32]=0x3C; wr_strobe_o pulses 5'b00001 then 5'b10000, one cycle each; err_o stays 0.
- Read addr 4 after the above (frame 0x04,0x00) -> cipo_o shifts out 0x3C MSB first; cipo_oe_o high only during the data phase; regs unchanged.
- Write to addr 7 (>=NUM_REGS), data 0xFF -> no register change, no strobe, err_o one pulse. Read addr 7 -> cipo_o shifts 0x00.
- 12-bit frame, then a 17-bit frame, both writes to addr 1 -> regs_o[15:8] stays 0; err_o pulses twice.
- Assert rst_n mid-frame after 9 bits, release, then send a full write 0x55 to addr 2 -> all outputs 0 during reset; afterwards regs_o[23:16]=0x55, no err_o.
- Re-run the first scenario with DATA_W=16, NUM_REGS=3, SYNC_STAGES=3 (write 0xBEEF to addr 2) -> regs_o[47:32]=0xBEEF; commit latency = 4 cycles after the nCS rise.
